result_uart_tx: RTL and testbench
=================================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 8: width of one accumulated PE result, fixed at one UART byte.
REQ-002 SHALL have parameter NUM_RES, default 4: number of results per readout (2x2 array).
REQ-003 SHALL have parameter CLKS_PER_BIT, default 868: clock cycles per UART bit; legal range 2 or more.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 asserts.
REQ-006 SHALL have port start  input  1  one-cycle request to snapshot and transmit results.
REQ-007 SHALL have port res_flat  input  NUM_RES*OUT_WIDTH  packed results; result i is bits [i*OUT_WIDTH +: OUT_WIDTH].
REQ-008 SHALL have port busy  output  1  high from snapshot until the last stop bit completes.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last stop bit.
REQ-010 SHALL have port tx  output  1  UART serial line, 8N1, idle high.

Function
REQ-011 SHALL implement FSM states IDLE, START_BIT, DATA_BITS, STOP_BIT, and NEXT.
REQ-012 IDLE with start=1 at edge k SHALL snapshot all of res_flat into an internal buffer, set result index=0, enter START_BIT, and drive busy=1 and tx=0 from edge k.
REQ-013 start while busy=1 SHALL be ignored with no effect on buffer, index or timing.
REQ-014 A res_flat change after the snapshot SHALL NOT affect transmitted data.
REQ-015 START_BIT SHALL hold tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA_BITS.
REQ-016 DATA_BITS SHALL send the current byte LSB first, each bit for CLKS_PER_BIT cycles, using a 3-bit bit counter; after bit 7 it SHALL enter STOP_BIT.
REQ-017 STOP_BIT SHALL hold tx=1 for CLKS_PER_BIT cycles.
REQ-018 After STOP_BIT, if index < NUM_RES-1, the block SHALL increment index and enter START_BIT directly, with no idle gap; a byte frame is exactly 10*CLKS_PER_BIT cycles.
REQ-019 After STOP_BIT of index NUM_RES-1, the block SHALL enter NEXT for one cycle with done=1, tx=1 and busy=1, then return to IDLE with busy=0.
REQ-020 Total busy duration SHALL be NUM_RES*10*CLKS_PER_BIT+1 cycles.
REQ-021 Results SHALL be sent in index order 0..NUM_RES-1.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on every bit boundary; its width SHALL be ceil(log2(CLKS_PER_BIT)).
REQ-023 start=1 in the same cycle that NEXT is active SHALL be ignored; start is accepted only in IDLE.
REQ-024 tx SHALL be registered, with no combinational path from any input to tx.

Reset
REQ-025 When reset=0, the block SHALL immediately set state=IDLE, tx=1, busy=0, done=0, and clear the counters, index and buffer to 0.
REQ-026 Reset asserted mid-frame SHALL abort transmission, with tx returning to 1 without completing the byte; after release the block SHALL await a new start.
REQ-027 The first start SHALL be accepted on the first rising edge at which reset=1 and start=1.

Verification (CLKS_PER_BIT=4, NUM_RES=4)
REQ-028 Single readout: res_flat=0x81_3C_00_A5 with a start pulse -> tx shows bytes A5,00,3C,81, each frame 0 LSB-first 1, 40 cycles per byte; busy=1 for 161 cycles; done pulses once.
REQ-029 Snapshot isolation: change res_flat to 0xFFFFFFFF one cycle after start -> transmitted bytes are unchanged from the original values.
REQ-030 Busy rejection: pulse start at cycles 10, 80 and 160 after the first start -> exactly one 4-byte sequence and one done pulse.
REQ-031 Back-to-back: start asserted on the cycle after done -> second sequence begins with tx=0 on that edge; stop-to-start spacing is 1 idle cycle.
REQ-032 Reset mid-operation: assert reset=0 during bit 3 of byte 1 -> tx=1, busy=0 within the same cycle; a new start after release sends all 4 bytes from index 0.
REQ-033 Bit timing check: res=0x55 -> tx alternates every 4 cycles across the data bits, with a start low and stop high of exactly 4 cycles each.

Source files
------------

// File: rtl/result_uart_tx.sv
// Serialises a snapshot of NUM_RES accumulated results over an 8N1 UART line,
// index 0 first, with busy covering the whole readout and a done pulse at the end.
module result_uart_tx #(
    parameter int OUT_WIDTH    = 8,
    parameter int NUM_RES      = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_RES*OUT_WIDTH-1:0]   res_flat,
    output logic                           busy,
    output logic                           done,
    output logic                           tx
);
    // state     | meaning
    // IDLE      | line high, waiting for start
    // START_BIT | driving the start bit (low) of the current byte
    // DATA_BITS | shifting the current byte out LSB first
    // STOP_BIT  | driving the stop bit (high) of the current byte
    // NEXT      | one-cycle done pulse after the last stop bit

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_RES - 1);

    typedef enum logic [2:0] {
        IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  baud_q, baud_d;
    logic [2:0]                     bit_q, bit_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [NUM_RES*OUT_WIDTH-1:0]   res_buf_q, res_buf_d;
    logic                           tx_q, tx_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [OUT_WIDTH-1:0]           cur_byte;
    logic                           bit_end;

    assign cur_byte = res_buf_q[int'(idx_q)*OUT_WIDTH +: OUT_WIDTH];
    assign bit_end  = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            res_buf_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            res_buf_q <= res_buf_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Outputs are computed one edge ahead so tx/busy/done come straight from flops.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        res_buf_d = res_buf_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    res_buf_d = res_flat;
                    idx_d     = '0;
                    baud_d    = '0;
                    bit_d     = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                    state_d = DATA_BITS;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + IW'(1);
                        tx_d    = 1'b0;
                        state_d = START_BIT;
                    end else begin
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = NEXT;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            NEXT: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Randomised readouts of result_uart_tx checked against a frame-level line model
// and a mid-bit UART receiver.
module tb_result_uart_tx;
    localparam int C   = 4;
    localparam int NR  = 4;
    localparam int FR  = 10 * C;
    localparam int TOT = NR * FR;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] res_flat = '0;
    logic        busy, done, tx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_uart_tx #(.OUT_WIDTH(8), .NUM_RES(NR), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .start(start), .res_flat(res_flat),
        .busy(busy), .done(done), .tx(tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Line level n cycles after the accepting edge: frames of start, 8 data LSB first, stop.
    function automatic logic model_tx(int n, logic [31:0] v);
        int slot;
        int pos;
        if (n >= TOT) return 1'b1;
        slot = n / FR;
        pos  = (n % FR) / C;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return v[slot*8 + pos - 1];
    endfunction

    // Called at a negedge with the DUT idle; start is sampled at the next posedge.
    task automatic run_readout(input logic [31:0] v, input bit scramble, input bit pester,
                               input int abort_at);
        logic [7:0] rx;
        int ph;
        rx = '0;
        start    = 1'b1;
        res_flat = v;
        for (int n = 0; n <= TOT; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 0 && scramble) res_flat = '1;
            if (pester && (n == 9 || n == 79 || n == 159 || n == 160)) start = 1'b1;
            if (n == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_now", 32'({tx, busy, done}), 32'b100);
                repeat (2) @(negedge clk);
                check("abort_hold", 32'({tx, busy, done}), 32'b100);
                reset = 1'b1;
                return;
            end
            check("wave", 32'({tx, busy, done}), 32'({model_tx(n, v), 1'b1, n == TOT}));
            ph = n % FR;
            if (n < TOT && ph >= C && ph < 9*C && (n % C) == C/2)
                rx[ph/C - 1] = tx;
            if (n < TOT && ph == 8*C + C/2)
                check("byte", 32'(rx), 32'(v[(n/FR)*8 +: 8]));
        end
        @(negedge clk);
        start = 1'b0;
        check("idle", 32'({tx, busy, done}), 32'b100);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", 32'({tx, busy, done}), 32'b100);
        reset = 1'b1;
        run_readout(32'h813C00A5, 1'b0, 1'b0, -1);
        run_readout(32'h55555555, 1'b0, 1'b0, -1);
        run_readout($urandom, 1'b1, 1'b0, -1);
        run_readout($urandom, 1'b0, 1'b1, -1);
        run_readout($urandom, 1'b0, 1'b0, -1);
        run_readout($urandom, 1'b0, 1'b0, 14*C + 1);
        run_readout(32'h813C00A5, 1'b0, 1'b0, -1);
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                check("gap", 32'({tx, busy, done}), 32'b100);
            end
            run_readout($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
